// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin 4:1 arbiter with bounded bursts and a registered, back-pressured output beat.
// Rev 1.0
`default_nettype none

module mux4_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic             out_ready,
  output logic [3:0]       gnt,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [3:0] c_LAST_BEAT = 4'(MAX_BURST - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_last, w_last_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_valid, w_valid_nxt;

  logic [1:0]       w_pick, w_idx;
  logic             w_found;
  logic             w_beat;
  logic [WIDTH-1:0] w_in;

  always_comb begin
    w_in = in0;
    case (r_sel)
      2'd0: w_in = in0;
      2'd1: w_in = in1;
      2'd2: w_in = in2;
      2'd3: w_in = in3;
      default: w_in = in0;
    endcase
  end

  // Priority scan starts just after the last-served requester and ends on it.
  always_comb begin
    w_pick  = r_last;
    w_found = 1'b0;
    w_idx   = r_last;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_beat = (r_state == GRANT) && req[r_sel] && (!r_valid || out_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_out_nxt   = r_out;
    w_valid_nxt = r_valid;

    if (r_valid && out_ready) begin
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = 4'b0001 << w_pick;
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_gnt_nxt   = 4'b0000;
        end
      end
      GRANT: begin
        if (!req[r_sel]) begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = 4'b0000;
          w_last_nxt  = r_sel;
          w_cnt_nxt   = 4'd0;
        end else if (w_beat) begin
          w_out_nxt   = w_in;
          w_valid_nxt = 1'b1;
          if (r_cnt == c_LAST_BEAT) begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = 4'b0000;
            w_last_nxt  = r_sel;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt   = r_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  // Reset leaves last=3 so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_cnt   <= 4'd0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_out   <= w_out_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign select    = r_sel;
  assign out       = r_out;
  assign out_valid = r_valid;
  assign busy      = (r_state == GRANT);

endmodule

`default_nettype wire

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: directed scenarios plus randomized traffic against a transaction-level arbiter model.
// Rev 1.0
`default_nettype none

module tb_mux4_arbiter;

  localparam int WIDTH = 32;
  localparam int MB    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [WIDTH-1:0] in0, in1, in2, in3;
  logic             out_ready;
  logic [3:0]       gnt;
  logic [1:0]       select;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, how many beats it has had, who was served last.
  int               m_owner = -1;
  int               m_beats = 0;
  int               m_last  = 3;
  logic [1:0]       m_sel   = 2'd0;
  logic [WIDTH-1:0] m_out   = '0;
  logic             m_valid = 1'b0;

  mux4_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_ready(out_ready), .gnt(gnt), .select(select),
    .out(out), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    logic [WIDTH-1:0] d[4];
    d[0] = in0; d[1] = in1; d[2] = in2; d[3] = in3;
    if (reset) begin
      m_owner = -1; m_beats = 0; m_last = 3; m_sel = 2'd0; m_out = '0; m_valid = 1'b0;
    end else if (m_owner < 0) begin
      if (m_valid && out_ready) m_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (m_owner < 0 && req[c]) begin
          m_owner = c; m_sel = 2'(c); m_beats = 0;
        end
      end
    end else if (!req[m_owner]) begin
      if (m_valid && out_ready) m_valid = 1'b0;
      m_last = m_owner; m_owner = -1;
    end else if (!m_valid || out_ready) begin
      m_out = d[m_owner]; m_valid = 1'b1; m_beats++;
      if (m_beats == MB) begin
        m_last = m_owner; m_owner = -1; m_beats = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0000; out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in0 = 32'hDEAD; in1 = 32'hBEEF; in2 = 32'h1; in3 = 32'h2;
    do_reset();
    checks++;
    if ({gnt, select, out, out_valid, busy} !== {4'b0, 2'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: gnt=%b select=%0d out=%h out_valid=%b busy=%b, required all zero",
               gnt, select, out, out_valid, busy);
    end
  endtask

  task automatic test_single();
    int n;
    do_reset();
    req = 4'b0001; in0 = 32'hA0; out_ready = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_grant_latency: gnt=%b busy=%b out_valid=%b, required 0001 1 0", gnt, busy, out_valid);
    end
    n = 1;
    tick();
    checks++;
    if (out !== 32'hA0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_first_beat: out=%h out_valid=%b, required a0 1", out, out_valid);
    end
    while (gnt == 4'b0001 && n < 10) begin n++; tick(); end
    checks++;
    if (n !== 4 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL single_burst_len: grant cycles=%0d gnt=%b, required 4 0000", n, gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL single_regrant: gnt=%b, required 0001", gnt);
    end
  endtask

  task automatic test_round_robin();
    int n;
    int idx;
    do_reset();
    req = 4'b1111; out_ready = 1'b1;
    in0 = 32'h10; in1 = 32'h11; in2 = 32'h12; in3 = 32'h13;
    for (int g = 0; g < 5; g++) begin
      idx = g % 4;
      tick();
      checks++;
      if (gnt !== (4'b0001 << idx) || select !== 2'(idx)) begin
        errors++;
        $display("FAIL rr_order[%0d]: gnt=%b select=%0d, required onehot(%0d)", g, gnt, select, idx);
      end
      n = 1;
      tick();
      checks++;
      if (out !== 32'(32'h10 + idx) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_data[%0d]: out=%h out_valid=%b, required %h 1", g, out, out_valid, 32'h10 + idx);
      end
      while (gnt == (4'b0001 << idx) && n < 10) begin n++; tick(); end
      checks++;
      if (n !== 4 || gnt !== 4'b0000) begin
        errors++;
        $display("FAIL rr_burst[%0d]: grant cycles=%0d gnt=%b, required 4 0000", g, n, gnt);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0100; in2 = 32'h22; out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0; in2 = 32'h33;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++;
      if (out !== 32'h22 || out_valid !== 1'b1 || gnt !== 4'b0100) begin
        errors++;
        $display("FAIL bp_freeze[%0d]: out=%h out_valid=%b gnt=%b, required 22 1 0100", s, out, out_valid, gnt);
      end
    end
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0100 || out !== 32'h33) begin
      errors++;
      $display("FAIL bp_resume: gnt=%b out=%h, required 0100 33", gnt, out);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL bp_end: gnt=%b, required 0000", gnt);
    end
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b1010; out_ready = 1'b1; in1 = 32'h55; in3 = 32'h77;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL drop_grant1: gnt=%b, required 0010", gnt);
    end
    tick(); tick();
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: gnt=%b busy=%b, required 0000 0", gnt, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL drop_next: gnt=%b, required 1000", gnt);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 4'b0010; out_ready = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) tick();
    req = 4'b1010;
    tick();
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL simul_winner: gnt=%b, required 1000", gnt);
    end
    for (int b = 0; b < 4; b++) tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++;
      $display("FAIL simul_gap: gnt=%b, required 0000", gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL simul_second: gnt=%b, required 0010", gnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b1111; out_ready = 1'b1; in0 = 32'h99;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({gnt, select, out, out_valid, busy} !== {4'b0, 2'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b select=%0d out=%h out_valid=%b busy=%b, required all zero",
               gnt, select, out, out_valid, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_regrant: gnt=%b, required 0001", gnt);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_gnt;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      req       = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) req = req | 4'((1 << m_sel) & 4'hF);
      in0       = $urandom; in1 = $urandom; in2 = $urandom; in3 = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) < 2);
      tick();
      exp_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
      checks++;
      if ({gnt, select, out, out_valid, busy} !== {exp_gnt, m_sel, m_out, m_valid, (m_owner >= 0)}) begin
        errors++;
        $display("FAIL random[%0d]: gnt=%b sel=%0d out=%h v=%b busy=%b, required gnt=%b sel=%0d out=%h v=%b busy=%b",
                 c, gnt, select, out, out_valid, busy, exp_gnt, m_sel, m_out, m_valid, (m_owner >= 0));
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 4'b0; out_ready = 1'b1;
    in0 = '0; in1 = '0; in2 = '0; in3 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
